// File: rtl/rst_cond.sv
// Reset conditioner: merges power-on reset, a debounced push-button and a filtered
// clock-manager lock into one registered, stretched reset request.
module rst_cond #(
    parameter int unsigned DEBOUNCE_CYCLES = 65536,
    parameter int unsigned LOCK_FILTER     = 16,
    parameter int unsigned STRETCH_CYCLES  = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    input  logic locked_i,
    output logic rst_o,
    output logic btn_evt_o,
    output logic lock_lost_o
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned LF_W = $clog2(LOCK_FILTER + 1);
    localparam int unsigned ST_W = $clog2(STRETCH_CYCLES + 1);

    typedef enum logic [1:0] {
        WAIT    = 2'd0,
        STRETCH = 2'd1,
        RUN     = 2'd2
    } state_e;

    logic            btn_meta_q, btn_s_q, lock_meta_q, lock_s_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            btn_db_q, btn_db_d;
    logic [LF_W-1:0] lk_cnt_q, lk_cnt_d;
    logic            lock_ok_q, lock_ok_d;
    state_e          state_q;
    logic [ST_W-1:0] st_cnt_q;
    logic            rst_q, btn_evt_q, lock_lost_q;

    // Two-flop synchronizers for the asynchronous inputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            btn_meta_q  <= 1'b0;
            btn_s_q     <= 1'b0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            btn_meta_q  <= btn_i;
            btn_s_q     <= btn_meta_q;
            lock_meta_q <= locked_i;
            lock_s_q    <= lock_meta_q;
        end
    end

    // Debounce: the state flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        db_cnt_d = db_cnt_q;
        btn_db_d = btn_db_q;
        if (btn_s_q == btn_db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            btn_db_d = ~btn_db_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    // Lock filter: any low sample drops lock_ok on the same edge.
    always_comb begin
        lk_cnt_d  = '0;
        lock_ok_d = 1'b0;
        if (lock_s_q) begin
            lk_cnt_d  = (lk_cnt_q == LF_W'(LOCK_FILTER)) ? lk_cnt_q : lk_cnt_q + LF_W'(1);
            lock_ok_d = (lk_cnt_q >= LF_W'(LOCK_FILTER - 1));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            db_cnt_q  <= '0;
            btn_db_q  <= 1'b0;
            lk_cnt_q  <= '0;
            lock_ok_q <= 1'b0;
        end else begin
            db_cnt_q  <= db_cnt_d;
            btn_db_q  <= btn_db_d;
            lk_cnt_q  <= lk_cnt_d;
            lock_ok_q <= lock_ok_d;
        end
    end

    // Sequencer; rst_q always tracks (next state != RUN).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= WAIT;
            st_cnt_q    <= '0;
            rst_q       <= 1'b1;
            btn_evt_q   <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            btn_evt_q <= 1'b0;
            case (state_q)
                WAIT: begin
                    if (lock_ok_q && !btn_db_q) begin
                        state_q  <= STRETCH;
                        st_cnt_q <= '0;
                    end
                end
                STRETCH: begin
                    if (!lock_ok_q || btn_db_q) begin
                        state_q <= WAIT;
                    end else if (st_cnt_q == ST_W'(STRETCH_CYCLES - 1)) begin
                        state_q <= RUN;
                        rst_q   <= 1'b0;
                    end else begin
                        st_cnt_q <= st_cnt_q + ST_W'(1);
                    end
                end
                RUN: begin
                    if (btn_db_q || !lock_ok_q) begin
                        state_q   <= WAIT;
                        rst_q     <= 1'b1;
                        btn_evt_q <= btn_db_q;
                        if (!lock_ok_q) lock_lost_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= WAIT;
                    rst_q   <= 1'b1;
                end
            endcase
        end
    end

    assign rst_o       = rst_q;
    assign btn_evt_o   = btn_evt_q;
    assign lock_lost_o = lock_lost_q;

endmodule

// File: doc/rst_cond.md
# rst_cond

Reset conditioner that sits directly upstream of the local reset stretcher: it merges the power-on reset, a raw push-button reset and the clock-manager lock indicator into one clean, glitch-free reset request. RST_O drives the asynchronous reset input of the local reset synchronizer. The block runs on a free-running input clock that does not depend on the clock manager it monitors. RST_O is held until lock is stable and the button is released, then for a programmable stretch period.

## Interface
- DEBOUNCE_CYCLES, 65536: consecutive agreeing samples required before the debounced button state changes (>=2).
- LOCK_FILTER, 16: consecutive high LOCKED samples required before lock is considered good (>=1).
- STRETCH_CYCLES, 256: cycles RST_O is held after all conditions are clear (>=1).
- CLK_I  in  1  free-running clock; all logic on rising edge.
- RST_I  in  1  reset, asynchronous, active-high (power-on / board reset).
- BTN_I  in  1  raw reset button, active-high, asynchronous to CLK_I, bouncy.
- LOCKED_I  in  1  clock-manager lock, active-high, asynchronous to CLK_I.
- RST_O  out  1  registered reset request, active-high.
- BTN_EVT_O  out  1  one-cycle pulse when a debounced button press forces reset from RUN.
- LOCK_LOST_O  out  1  sticky flag, set when lock drops while in RUN; cleared only by RST_I.

## Operation
- BTN_I and LOCKED_I each pass through a 2-flop synchronizer (btn_s, lock_s); synchronizer flops reset to 0.
- Debounce: counter clears whenever btn_s equals btn_db and increments while they differ. btn_db toggles at the edge that takes the DEBOUNCE_CYCLES-th consecutive differing sample; the counter then clears. Width is ceil(log2(DEBOUNCE_CYCLES))+1 bits, saturating and never wrapping.
- Lock filter: counter increments on each high lock_s sample and saturates at LOCK_FILTER. lock_ok is set at the edge that takes the LOCK_FILTER-th consecutive high sample. Any low lock_s sample clears both the counter and lock_ok at that same edge.
- FSM states:
  - WAIT: RST_O=1. Go to STRETCH when lock_ok=1 and btn_db=0; stretch counter loads 0.
  - STRETCH: RST_O=1; counter increments. Return to WAIT if lock_ok=0 or btn_db=1; this takes priority over completion. Go to RUN at the edge where the counter equals STRETCH_CYCLES-1.
  - RUN: RST_O=0. Go to WAIT if btn_db=1 or lock_ok=0.
- RST_O is registered as (next_state != RUN), so it changes at the same edge as the state.
- BTN_EVT_O is high for exactly the one cycle after a RUN->WAIT transition caused by btn_db=1.
- LOCK_LOST_O sets on a RUN->WAIT transition where lock_ok=0.
- If the button press and the lock loss take effect on the same edge in RUN, both BTN_EVT_O and LOCK_LOST_O set.
- A button press or lock loss during WAIT or STRETCH sets neither flag.

## Timing
- Reset values while RST_I=1: state WAIT, RST_O=1, BTN_EVT_O=0, LOCK_LOST_O=0, all counters 0, btn_db=0, lock_ok=0.
- Edge numbering: edge k is the k-th rising CLK_I edge after RST_I falls; an input change is sampled first at edge 1.
- Power-up with LOCKED_I high and BTN_I low: lock_ok=1 at edge 2+LOCK_FILTER; STRETCH entered at edge 3+LOCK_FILTER; RST_O falls at edge 3+LOCK_FILTER+STRETCH_CYCLES.
- Button press in RUN, with BTN_I changing before edge 1: btn_db=1 at edge 2+DEBOUNCE_CYCLES; RST_O rises at edge 3+DEBOUNCE_CYCLES; BTN_EVT_O is high during the following cycle.
- Lock loss in RUN, with LOCKED_I falling before edge 1: lock_ok=0 at edge 3; RST_O rises and LOCK_LOST_O sets at edge 4.
- Button release restarts the sequence: btn_db clears after DEBOUNCE_CYCLES stable samples, then one cycle to STRETCH, then the full STRETCH_CYCLES count.
- RST_I asserted at any point, including mid-STRETCH: all outputs take their reset values immediately (asynchronous) and the sequence restarts from edge 1 after release.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=8, LOCK_FILTER=3, STRETCH_CYCLES=4.
- Power-up, LOCKED_I=1, BTN_I=0 -> RST_O=1 through edge 9, RST_O=0 from edge 10; both flags stay 0.
- In RUN, BTN_I high for 7 cycles, then low -> RST_O stays 0 and BTN_EVT_O stays 0.
- In RUN, BTN_I held high, changing before edge 1 -> RST_O=1 at edge 11; BTN_EVT_O=1 for one cycle. On release, RST_O falls exactly 8+1+4 edges after btn_db clears is processed.
- In RUN, LOCKED_I low for 1 cycle -> RST_O=1 at edge 4 and LOCK_LOST_O=1. After relock, RST_O falls 3+1+4 edges after lock_s returns high. LOCK_LOST_O stays 1 until RST_I.
- LOCKED_I drops at the 2nd STRETCH cycle -> back to WAIT, RST_O never falls, LOCK_LOST_O remains 0.
- RST_I pulsed mid-STRETCH, with LOCK_LOST_O previously set -> RST_O=1, LOCK_LOST_O=0 immediately; after release the power-up timing above repeats exactly.
